// File: rtl/reg_unit_pair.sv
// Two chained WIDTH-bit registers A:B with load and combined right shift, plus a shift sequencer.
// Define PROTO_CHECK_EN to build the sticky strobe-protocol checker that drives Proto_Err.
module reg_unit_pair #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Ld_A,
    input  logic             Ld_B,
    input  logic             Shift_En,
    input  logic             Shift_In,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic             Shift_Out,
    output logic [CNT_W-1:0] Shift_Count,
    output logic             Done,
    output logic             Proto_Err
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SHIFTING = 2'd1,
        ST_DONE     = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, count_nxt;
    logic               load;
    logic [2*WIDTH-1:0] ab_shift;

    assign load = Ld_A | Ld_B;

    // Shift_In enters the top of A; the bit dropped by the shift is B[0].
    assign ab_shift = (2*WIDTH)'({Shift_In, A, B} >> 1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            A <= '0;
            B <= '0;
        end else if (load) begin
            if (Ld_A) A <= D;
            if (Ld_B) B <= D;
        end else if (Shift_En) begin
            {A, B} <= ab_shift;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        if (load) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
        end else if (Shift_En) begin
            unique case (state)
                ST_IDLE: begin
                    count_nxt = CNT_W'(1);
                    state_nxt = (WIDTH == 1) ? ST_DONE : ST_SHIFTING;
                end
                ST_SHIFTING: begin
                    count_nxt = count + CNT_W'(1);
                    if (count_nxt == CNT_MAX) state_nxt = ST_DONE;
                end
                ST_DONE: begin
                    count_nxt = CNT_MAX;
                end
                default: begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                end
            endcase
        end
    end

    assign Shift_Out   = B[0];
    assign Shift_Count = count;
    assign Done        = (state == ST_DONE);

`ifdef PROTO_CHECK_EN
    logic violation;
    logic proto_err;

    // A violation raised alongside a load overrides the load's clear.
    always_comb begin
        violation = (load & Shift_En)
                  | ((state == ST_SHIFTING) & ~Shift_En)
                  | ((state == ST_DONE) & Shift_En);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            proto_err <= 1'b0;
        end else if (violation) begin
            proto_err <= 1'b1;
        end else if (load) begin
            proto_err <= 1'b0;
        end
    end

    assign Proto_Err = proto_err;
`else
    assign Proto_Err = 1'b0;
`endif

endmodule

// File: tb/tb_reg_unit_pair.sv
// Self-checking bench for reg_unit_pair: directed scenarios then randomized strobes against a
// shift-count based reference model. Honours PROTO_CHECK_EN the same way as the design.
module tb_reg_unit_pair;

    localparam int W = 8;

    logic         Clk;
    logic         Reset_n;
    logic         Ld_A;
    logic         Ld_B;
    logic         Shift_En;
    logic         Shift_In;
    logic [W-1:0] D;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Shift_Out;
    logic [3:0]   Shift_Count;
    logic         Done;
    logic         Proto_Err;

    int checks = 0;
    int errors = 0;

    // Reference model: register contents plus the raw number of shifts since the last load.
    logic [W-1:0] ma;
    logic [W-1:0] mb;
    int           mn;
    logic         mperr;

`ifdef PROTO_CHECK_EN
    localparam bit PROTO = 1'b1;
`else
    localparam bit PROTO = 1'b0;
`endif

    reg_unit_pair #(.WIDTH(W)) dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .Ld_A        (Ld_A),
        .Ld_B        (Ld_B),
        .Shift_En    (Shift_En),
        .Shift_In    (Shift_In),
        .D           (D),
        .A           (A),
        .B           (B),
        .Shift_Out   (Shift_Out),
        .Shift_Count (Shift_Count),
        .Done        (Done),
        .Proto_Err   (Proto_Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        ma    = '0;
        mb    = '0;
        mn    = 0;
        mperr = 1'b0;
    endtask

    // One clock edge of the specified behaviour, using the strobes present before the edge.
    task automatic model_edge(input logic la, input logic lb, input logic sh,
                              input logic si, input logic [W-1:0] d);
        logic         ld;
        logic         viol;
        logic [2*W:0] wide;
        ld   = la | lb;
        viol = (ld & sh) | ((mn > 0) && (mn < W) && !sh) | ((mn >= W) && sh);
        if (ld) begin
            if (la) ma = d;
            if (lb) mb = d;
            mn = 0;
        end else if (sh) begin
            wide = {si, ma, mb};
            wide = wide >> 1;
            ma   = wide[2*W-1:W];
            mb   = wide[W-1:0];
            if (mn <= W) mn = mn + 1;
        end
        if (!PROTO)    mperr = 1'b0;
        else if (viol) mperr = 1'b1;
        else if (ld)   mperr = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        int exp_cnt;
        exp_cnt = (mn > W) ? W : mn;
        check({tag, ".A"},         32'(A),           32'(ma));
        check({tag, ".B"},         32'(B),           32'(mb));
        check({tag, ".Shift_Out"}, 32'(Shift_Out),   32'(mb[0]));
        check({tag, ".Count"},     32'(Shift_Count), 32'(exp_cnt));
        check({tag, ".Done"},      32'(Done),        32'(mn >= W));
        check({tag, ".Proto_Err"}, 32'(Proto_Err),   32'(mperr));
    endtask

    task automatic step(input string tag, input logic la, input logic lb, input logic sh,
                        input logic si, input logic [W-1:0] d);
        Ld_A     = la;
        Ld_B     = lb;
        Shift_En = sh;
        Shift_In = si;
        D        = d;
        model_edge(la, lb, sh, si, d);
        @(posedge Clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [7:0] so_seq;
        logic       la, lb, sh;
        int         r;

        Reset_n  = 1'b0;
        Ld_A     = 1'b0;
        Ld_B     = 1'b0;
        Shift_En = 1'b0;
        Shift_In = 1'b0;
        D        = '0;
        model_reset();
        #12;
        compare_all("reset");
        @(negedge Clk);
        Reset_n = 1'b1;

        // 1: load B=0x07, A=0x00, eight shifts of ones
        step("t1_ldb", 1'b0, 1'b1, 1'b0, 1'b0, 8'h07);
        step("t1_lda", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        so_seq = 8'b1110_0000;
        for (int i = 0; i < 8; i++) begin
            check("t1_shift_out_seq", 32'(Shift_Out), 32'(so_seq[7-i]));
            step("t1_sh", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        end
        check("t1_A_final", 32'(A), 32'h0000_00FF);
        check("t1_B_final", 32'(B), 32'h0000_0000);
        check("t1_count",   32'(Shift_Count), 32'd8);
        check("t1_done",    32'(Done), 32'd1);

        // 2: asynchronous reset after the fourth shift of a burst
        step("t2_lda", 1'b1, 1'b1, 1'b0, 1'b0, 8'h96);
        for (int i = 0; i < 4; i++) step("t2_sh", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        Shift_En = 1'b0;
        #2;
        Reset_n = 1'b0;
        #1;
        model_reset();
        check("t2_async_A",     32'(A),           32'd0);
        check("t2_async_B",     32'(B),           32'd0);
        check("t2_async_count", 32'(Shift_Count), 32'd0);
        check("t2_async_done",  32'(Done),        32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        step("t2_restart", 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        check("t2_restart_count", 32'(Shift_Count), 32'd1);

        // 3: load and shift strobed together
        step("t3_ldb", 1'b0, 1'b1, 1'b0, 1'b0, 8'h3C);
        step("t3_lda_sh", 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A);
        check("t3_A",     32'(A),           32'h5A);
        check("t3_B",     32'(B),           32'h3C);
        check("t3_count", 32'(Shift_Count), 32'd0);
        check("t3_perr",  32'(Proto_Err),   32'(PROTO));

        // 4: three shifts, one gap, five shifts
        step("t4_ld", 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 3; i++) step("t4_sh_a", 1'b0, 1'b0, 1'b1, i[0], 8'h00);
        step("t4_gap", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 3; i < 8; i++) step("t4_sh_b", 1'b0, 1'b0, 1'b1, i[0], 8'h00);
        // {A5,A5} after 8 shifts with Shift_In sequence 0,1,0,1,0,1,0,1 (MSB-first arrival)
        check("t4_A",    32'(A),         32'hAA);
        check("t4_B",    32'(B),         32'hA5);
        check("t4_done", 32'(Done),      32'd1);
        check("t4_perr", 32'(Proto_Err), 32'(PROTO));

        // 5: overshift in DONE, then a clean Ld_B
        step("t5_over", 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check("t5_A",     32'(A),           32'h55);
        check("t5_B",     32'(B),           32'h52);
        check("t5_count", 32'(Shift_Count), 32'd8);
        check("t5_perr",  32'(Proto_Err),   32'(PROTO));
        step("t5_ldb", 1'b0, 1'b1, 1'b0, 1'b0, 8'h11);
        check("t5_done_clr", 32'(Done),      32'd0);
        check("t5_perr_clr", 32'(Proto_Err), 32'd0);

        // 6: both loads at once
        step("t6_ldab", 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3);
        check("t6_A",  32'(A),         32'hC3);
        check("t6_B",  32'(B),         32'hC3);
        check("t6_so", 32'(Shift_Out), 32'd1);

        // Randomized strobes against the reference model
        for (int i = 0; i < 400; i++) begin
            r  = int'($urandom_range(0, 99));
            la = (r < 8);
            lb = (r >= 5) && (r < 13);
            sh = ($urandom_range(0, 99) < 80);
            step("rnd", la, lb, sh, 1'($urandom), 8'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
